// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit FIFO write port between
// NUM_REQ byte producers, holding each grant for a whole packet or MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int GW       = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_we,
  output logic [7:0]           fifo_data,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  // Handshake: a byte from requester i moves into the FIFO in exactly the cycle
  // where req_valid[i] & req_ready[i] are high; that is also the only cycle with
  // fifo_we high. req_ready never depends on anything but the current grantee.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_last_grant;
  logic [7:0]    r_burst_cnt;

  logic          w_any;
  logic          w_found;
  logic [GW-1:0] w_idx;
  logic [GW-1:0] w_sel;
  logic          w_xfer;
  logic          w_cap_hit;
  logic [7:0]    w_data;

  // Rotating search starting just after the previous grantee.
  always_comb begin
    w_any   = |req_valid;
    w_found = 1'b0;
    w_sel   = r_last_grant;
    w_idx   = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == GW'(NUM_REQ - 1)) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + 1'b1;
      end
      if (!w_found && req_valid[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_data = req_data[8*i +: 8];
      end
    end
  end

  // Reset gates the transfer combinationally so an abandoned grant writes nothing.
  assign w_xfer    = (r_state == S_GRANT) & req_valid[r_grant_id] & ~fifo_full & ~reset_i;
  assign w_cap_hit = (({1'b0, r_burst_cnt} + 9'd1) == 9'(MAX_BURST));

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_grant_id  <= w_sel;
        r_burst_cnt <= '0;
      end
      if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
        if (w_state_nxt == S_IDLE) begin
          r_last_grant <= r_grant_id;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_xfer && (req_last[r_grant_id] || w_cap_hit)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; busy doubles as the externally visible FSM state.
  always_comb begin
    req_ready             = '0;
    req_ready[r_grant_id] = w_xfer;
    fifo_we               = w_xfer;
    fifo_data             = w_xfer ? w_data : 8'h00;
    grant_id              = r_grant_id;
    busy                  = (r_state == S_GRANT);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO between NUM_REQ independent byte producers, such as a CPU CSR path, a debug monitor and a DMA engine.
- Grants the FIFO write port to one requester per packet, so bytes from different producers never interleave on the wire.
- Uses round-robin selection between packets.
- A per-grant burst cap prevents one long packet from starving the other requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes written per grant before forced re-arbitration (1..255).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte available.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  the presented byte is the last of requester i's packet.
- req_ready  out  NUM_REQ  requester i's byte is consumed this cycle.
- fifo_full  in  1  the transmit FIFO cannot accept a write this cycle.
- fifo_we  out  1  FIFO write enable.
- fifo_data  out  8  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee.
- busy  out  1  high while in GRANT.

Behaviour:
- State machine states: IDLE and GRANT.
- Registers:
  - state
  - grant_id
  - last_grant
  - burst_cnt (8 bits)
- Reset (sampled on clk_i rising edge while reset_i=1):
  - state=IDLE
  - grant_id=0
  - last_grant=NUM_REQ-1, so requester 0 wins first
  - burst_cnt=0
  - all outputs low
  - Reset mid-packet abandons the grant immediately; no further fifo_we in that cycle or after it.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Load grant_id with the selection, clear burst_cnt, go to GRANT.
  - Arbitration latency is exactly 1 cycle. No byte is written in IDLE.
  - If no req_valid bit is set, stay in IDLE.
- GRANT (combinational outputs):
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_we = xfer.
  - fifo_data = req_data[grant_id].
  - req_ready = xfer << grant_id; only the grantee is ever readied.
  - fifo_data is don't-care when fifo_we=0.
- On each xfer:
  - burst_cnt increments.
  - If req_last[grant_id]=1, or burst_cnt+1 == MAX_BURST: last_grant<=grant_id, state<=IDLE.
- Grant retention:
  - The grantee dropping req_valid mid-packet does not release the grant. The block waits in GRANT, writing nothing, until the packet resumes.
  - Producers must deliver packets contiguously, or mark packet boundaries with req_last.
- fifo_full=1 stalls the transfer: no write, no ready, state held. The byte is retried every cycle until accepted.
- Burst-cap release: the requester re-arbitrates in IDLE with lowest round-robin priority. Its packet continues in a later grant.
- Simultaneous requests are resolved purely by rotation; there is no fixed priority.
- Requests arriving while in GRANT are ignored until the return to IDLE.
- Sustained throughput with contention: MAX_BURST bytes per MAX_BURST+1 cycles.
- busy=1 exactly while state==GRANT.
- grant_id holds its value in IDLE.

Test Plan:
- Single requester:
  - Stimulus: req 1 sends DE,AD,BE,EF with last on EF, fifo_full=0.
  - Required: 1 idle cycle, then fifo_we high for 4 consecutive cycles, fifo_data DE,AD,BE,EF, req_ready=4'b0010 on each, busy drops the cycle after EF.
- Round-robin:
  - Stimulus: reqs 0,2,3 each hold a 1-byte packet (last=1) from cycle 0.
  - Required: grant order 0,2,3; each write is preceded by one IDLE cycle; 6 cycles total.
- Back-pressure:
  - Stimulus: req 0 sends 3 bytes 11,22,33; fifo_full=1 for 5 cycles while byte 22 is presented.
  - Required: no fifo_we and req_ready[0]=0 during the stall; 22 written the cycle full falls; no duplicate writes.
- Burst cap (MAX_BURST=16):
  - Stimulus: req 0 streams a 40-byte packet while req 1 waits with a 2-byte packet.
  - Required: sequence of 16 bytes req0, 2 bytes req1, 16 bytes req0, 8 bytes req0.
- Valid gap:
  - Stimulus: req 2 drops valid for 3 cycles mid-packet while req 0 requests.
  - Required: grant_id stays 2, fifo_we=0 in the gap, req 0 is served only after req 2's last byte.
- Reset mid-packet:
  - Stimulus: assert reset_i during byte 2 of a 4-byte packet.
  - Required: fifo_we=0 from that cycle; after release, requester 0 wins first when requests are pending.
